// File: rtl/instr_encoder_pkg.sv
// Shared MIPS field layout, opcode constants and the field-set struct used by
// both the encoder and the decode-side field splitter.
package instr_encoder_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;

  // LSB positions of each field inside the 32-bit word
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

  localparam logic FMT_R = 1'b0;
  localparam logic FMT_I = 1'b1;

  typedef struct packed {
    logic               fmt;
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
  } fields_t;

  // Pack a field set; R-type forces the opcode to zero, I-type drops rd/shamt/funct
  function automatic logic [INSTR_W-1:0] encode(input fields_t f);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[RS_LSB +: REG_W] = f.rs;
    w[RT_LSB +: REG_W] = f.rt;
    if (f.fmt == FMT_I) begin
      w[OP_LSB  +: OP_W]  = f.opcode;
      w[IMM_LSB +: IMM_W] = f.imm;
    end else begin
      w[OP_LSB    +: OP_W]    = OP_RTYPE;
      w[RD_LSB    +: REG_W]   = f.rd;
      w[SHAMT_LSB +: SHAMT_W] = f.shamt;
      w[FUNCT_LSB +: FUNCT_W] = f.funct;
    end
    return w;
  endfunction

  // I-type opcodes that collide with R-type or J-format words cannot be encoded
  function automatic logic is_illegal(input fields_t f);
    return (f.fmt == FMT_I) &&
           (f.opcode == OP_RTYPE || f.opcode == OP_J || f.opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO, head exposed combinationally; writes ignored when full,
// reads ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wptr, rptr;
  logic                        do_wr, do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  // Storage is cleared on reset so the head reads zero until the first write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem       <= '0;
    else if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally; count tracks occupancy for simultaneous push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs MIPS field sets into instruction words and streams them out through a
// FIFO together with a running byte address for instruction-memory loading.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fmt,
  input  logic [5:0]         opcode,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic [4:0]         shamt,
  input  logic [5:0]         funct,
  input  logic [15:0]        imm,
  input  logic               clr_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic [ADDR_W-1:0]  addr,
  output logic [CNT_W-1:0]   count,
  output logic               err
);

  fields_t            req;
  logic [INSTR_W-1:0] word;
  logic               accept, bad, push, pop, full, empty;

  assign req = '{fmt: fmt, opcode: opcode, rs: rs, rt: rt, rd: rd,
                 shamt: shamt, funct: funct, imm: imm};

  assign word      = encode(req);
  assign bad       = is_illegal(req);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  // Illegal sets complete the handshake but never reach the FIFO
  assign push      = accept && !bad;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (word),
    .rd_en   (pop),
    .rd_data (instr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Head byte address advances one word per pop, wrapping silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   addr <= BASE_ADDR;
    else if (pop) addr <= addr + ADDR_W'(4);
  end

  // Sticky error: an illegal accept wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err <= 1'b0;
    else if (accept && bad)  err <= 1'b1;
    else if (clr_err)        err <= 1'b0;
  end

endmodule
